// File: rtl/obi_mem_pkg.sv
// Shared types and parameter limits for the OBI memory responder.
package obi_mem_pkg;

    localparam int unsigned MAX_WAIT_STATES  = 15;
    localparam int unsigned MAX_RESP_LATENCY = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        READY
    } obi_mem_state_e;

    typedef struct packed {
        logic        valid;
        logic        err;
        logic [31:0] rdata;
    } obi_mem_resp_t;

endpackage

// File: rtl/obi_mem_resp_pipe.sv
// Fixed-latency response shift register; reset discards in-flight responses.
module obi_mem_resp_pipe
    import obi_mem_pkg::*;
#(
    parameter int unsigned LATENCY = 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  obi_mem_resp_t resp_i,
    output obi_mem_resp_t resp_o
);

    obi_mem_resp_t stage_q [LATENCY];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= resp_i;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign resp_o = stage_q[LATENCY-1];

endmodule

// File: rtl/obi_mem_responder.sv
// OBI-style word memory responder with programmable grant wait states and
// fixed response latency; out-of-range accesses answer with err set.
module obi_mem_responder
    import obi_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS  = 1024,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000,
    parameter int unsigned WAIT_STATES  = 0,
    parameter int unsigned RESP_LATENCY = 1
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    input  logic        stall_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        err_o
);

    localparam int unsigned IDX_W      = $clog2(DEPTH_WORDS);
    localparam logic [3:0]  WS_L       = 4'(WAIT_STATES);
    localparam logic [32:0] SIZE_BYTES = 33'(DEPTH_WORDS) << 2;

    if (WAIT_STATES > MAX_WAIT_STATES) begin : g_ws_chk
        $error("obi_mem_responder: WAIT_STATES out of range 0..15");
    end
    if (RESP_LATENCY < 1 || RESP_LATENCY > MAX_RESP_LATENCY) begin : g_lat_chk
        $error("obi_mem_responder: RESP_LATENCY out of range 1..4");
    end
    if (DEPTH_WORDS < 2 || DEPTH_WORDS > 32'h4000_0000 ||
        (DEPTH_WORDS & (DEPTH_WORDS - 1)) != 0) begin : g_depth_chk
        $error("obi_mem_responder: DEPTH_WORDS must be a power of two >= 2");
    end

    obi_mem_state_e   state_q, state_d;
    logic [3:0]       wait_cnt_q, wait_cnt_d;
    logic             accept;
    logic [31:0]      offset;
    logic             in_range;
    logic [IDX_W-1:0] word_idx;
    logic [31:0]      mem [DEPTH_WORDS];
    obi_mem_resp_t    resp_d, resp_q;

    assign gnt_o  = rst_ni & req_i & ~stall_i & (wait_cnt_q == WS_L);
    assign accept = req_i & gnt_o;

    // The offset compare is done in 33 bits so BASE_ADDR + size cannot wrap.
    assign offset   = addr_i - BASE_ADDR;
    assign in_range = (addr_i >= BASE_ADDR) && ({1'b0, offset} < SIZE_BYTES);
    assign word_idx = offset[IDX_W+1:2];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            IDLE: begin
                wait_cnt_d = '0;
                if (req_i && !gnt_o) begin
                    if (WS_L == '0) begin
                        state_d = READY;
                    end else begin
                        wait_cnt_d = 4'd1;
                        state_d    = (WS_L == 4'd1) ? READY : WAIT;
                    end
                end
            end
            WAIT: begin
                if (!req_i) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 4'd1;
                    if (wait_cnt_d == WS_L) state_d = READY;
                end
            end
            READY: begin
                if (accept || !req_i) begin
                    state_d    = IDLE;
                    wait_cnt_d = '0;
                end
            end
            default: begin
                state_d    = IDLE;
                wait_cnt_d = '0;
            end
        endcase
    end

    // Array is deliberately not reset so contents survive rst_ni.
    always_ff @(posedge clk_i) begin
        if (accept && we_i && in_range) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (be_i[b]) mem[word_idx][8*b +: 8] <= wdata_i[8*b +: 8];
            end
        end
    end

    always_comb begin
        resp_d = '0;
        if (accept) begin
            resp_d.valid = 1'b1;
            if (!in_range)  resp_d.err   = 1'b1;
            else if (!we_i) resp_d.rdata = mem[word_idx];
        end
    end

    obi_mem_resp_pipe #(
        .LATENCY(RESP_LATENCY)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_ni(rst_ni),
        .resp_i(resp_d),
        .resp_o(resp_q)
    );

    assign rvalid_o = resp_q.valid;
    assign rdata_o  = resp_q.rdata;
    assign err_o    = resp_q.err;

endmodule

// File: doc/obi_mem_responder.md
OBI_MEM_RESPONDER -- requirements
Module: obi_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024: memory size in 32-bit words (power of two).
REQ-002 SHALL have parameter BASE_ADDR, default 32'h0000_0000: byte address of word 0.
REQ-003 SHALL have parameter WAIT_STATES, default 0 (range 0..15): request cycles held before grant.
REQ-004 SHALL have parameter RESP_LATENCY, default 1 (range 1..4): cycles from accept edge to rvalid_o.
REQ-005 SHALL have port clk_i  input  1  single clock, rising edge.
REQ-006 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-007 SHALL have port req_i  input  1  initiator request.
REQ-008 SHALL have port gnt_o  output  1  request accepted this cycle.
REQ-009 SHALL have port addr_i  input  32  byte address.
REQ-010 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-011 SHALL have port be_i  input  4  byte enables.
REQ-012 SHALL have port wdata_i  input  32  write data.
REQ-013 SHALL have port stall_i  input  1  test hook; forces gnt_o low.
REQ-014 SHALL have port rvalid_o  output  1  response valid, one cycle per accepted request.
REQ-015 SHALL have port rdata_o  output  32  read data.
REQ-016 SHALL have port err_o  output  1  error flag, qualified by rvalid_o.

Function
REQ-017 Accept SHALL be defined as req_i & gnt_o at a rising clk_i edge; at most one accept per cycle.
REQ-018 gnt_o SHALL be combinational: req_i & ~stall_i & (wait_cnt == WAIT_STATES).
REQ-019 The grant FSM SHALL have three states: IDLE, WAIT, READY.
REQ-020 IDLE: wait_cnt = 0. On req_i, go to READY if WAIT_STATES = 0, else to WAIT.
REQ-021 WAIT: wait_cnt increments each cycle while req_i is high; go to READY when it reaches WAIT_STATES; return to IDLE with wait_cnt = 0 if req_i drops.
REQ-022 READY: on accept, go to IDLE (wait_cnt = 0). While stall_i holds, stay in READY (no grant); return to IDLE if req_i drops.
REQ-023 Word index SHALL be (addr_i - BASE_ADDR) >> 2; addr_i[1:0] SHALL be ignored.
REQ-024 An address is in range iff BASE_ADDR <= addr_i < BASE_ADDR + 4*DEPTH_WORDS (unsigned 32-bit compare, no wrap).
REQ-025 An in-range write SHALL update, at the accept edge, only the bytes whose be_i bit is 1; be_i = 0 is a no-op that still returns a response.
REQ-026 An in-range read SHALL sample the array at the accept edge, including a write accepted on the previous edge (read-after-write coherent).
REQ-027 Every accept SHALL produce exactly one rvalid_o pulse RESP_LATENCY cycles later, in order; no backpressure exists.
REQ-028 Response fields:
- read: rdata = word, err = 0
- write: rdata = 0, err = 0
- out-of-range (either type): rdata = 0, err = 1, array untouched
REQ-029 While rvalid_o = 0, rdata_o and err_o SHALL be 0.
REQ-030 Back-to-back accepts (WAIT_STATES = 0) SHALL sustain one response per cycle.

Reset
REQ-031 On rst_ni low: FSM = IDLE, wait_cnt = 0, all pipeline valid bits = 0, rvalid_o = 0, rdata_o = 0, err_o = 0.
REQ-032 Responses in flight when reset is asserted SHALL be discarded; no rvalid_o SHALL be emitted for them after release.
REQ-033 Array contents SHALL NOT be reset and SHALL survive reset.
REQ-034 gnt_o SHALL be 0 while rst_ni is low.

Structure
REQ-035 Shared package obi_mem_pkg SHALL hold:
- typedef obi_mem_state_e {IDLE, WAIT, READY}
- packed struct obi_mem_resp_t {valid, err, rdata[31:0]}
- parameter limits (MAX_WAIT_STATES = 15, MAX_RESP_LATENCY = 4)
REQ-036 A sub-module obi_mem_resp_pipe SHALL implement the RESP_LATENCY-stage shift register of obi_mem_resp_t, asynchronously cleared by rst_ni.
REQ-037 Out-of-range parameter values SHALL raise an elaboration-time error.

Verification
REQ-038 WAIT_STATES = 0, RESP_LATENCY = 1: write 0xDEADBEEF to 0x10 (be = 4'hF), read 0x10 the next cycle -> gnt_o in the request cycles, rvalid_o one cycle after each accept, second rdata_o = 0xDEADBEEF, err_o = 0.
REQ-039 Partial write: preload 0x11223344 at 0x20, write 0xAABBCCDD with be = 4'b0101 -> read returns 0x11BB33DD.
REQ-040 WAIT_STATES = 3: req_i held -> gnt_o first high in the 4th request cycle; if req_i drops after cycle 2 and reasserts -> count restarts, grant after 3 further waits.
REQ-041 Address 4*DEPTH_WORDS (first out-of-range word): read -> rvalid_o with err_o = 1, rdata_o = 0; a subsequent read of word 0 is unchanged.
REQ-042 RESP_LATENCY = 3: four back-to-back reads -> four consecutive rvalid_o pulses starting 3 cycles after the first accept, in request order. Assert rst_ni low after the 2nd accept -> no rvalid_o after release; memory contents intact.
REQ-043 stall_i high for 5 cycles with req_i held -> gnt_o stays 0; grant in the first cycle after stall_i falls.
